// File: rtl/div_ctrl_pkg.sv
// Shared types for the div_gen_0 sequencer: data widths, FSM state encoding
// and a conditional two's-complement negate used for magnitudes and sign fix-up.
package div_ctrl_pkg;

  localparam int DATA_W  = 32;
  localparam int DDATA_W = 2 * DATA_W;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [DDATA_W-1:0] ddata_t;

  typedef enum logic [2:0] {
    DIVC_IDLE  = 3'd0,
    DIVC_ISSUE = 3'd1,
    DIVC_WAIT  = 3'd2,
    DIVC_FIX   = 3'd3,
    DIVC_DONE  = 3'd4
  } divc_state_e;

  // -0x80000000 wraps to itself, which is exactly the unsigned magnitude we want.
  function automatic data_t cond_neg(input data_t value, input logic neg);
    return neg ? data_t'(-value) : value;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Pipeline-side request/result bundle of the divide controller.
// master = EX stage, slave = div_ctrl.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic  start;
  logic  signed_div;
  data_t dividend;
  data_t divisor;
  logic  flush;
  logic  busy;
  logic  done;
  data_t quotient;
  data_t remainder;

  modport master (
    output start, signed_div, dividend, divisor, flush,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, signed_div, dividend, divisor, flush,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/div_sign_fix.sv
// Combinational post-correction: unsigned quotient/remainder magnitudes plus
// sign flags become signed results. Shared with the multicycle MULT controller.
module div_sign_fix
  import div_ctrl_pkg::*;
(
  input  data_t quot_mag,
  input  data_t rem_mag,
  input  logic  neg_quot,
  input  logic  neg_rem,
  output data_t quot,
  output data_t rem
);

  assign quot = cond_neg(quot_mag, neg_quot);
  assign rem  = cond_neg(rem_mag, neg_rem);

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the fixed-latency div_gen_0 IP: holds IP operands, counts its
// latency, fixes signs and pulses done. Option: DIV_CTRL_ZERO_FAST_EN.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 36
) (
  input  logic   clk,
  input  logic   rst,
  div_ctrl_if.slave bus,
  output data_t  div_dividend,
  output data_t  div_divisor,
  input  ddata_t div_dout
);

  localparam int              CNT_W    = $clog2(DIV_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  divc_state_e      state;
  logic [CNT_W-1:0] counter;
  logic             neg_quot;
  logic             neg_rem;
  logic             busy_r;
  logic             done_r;
  data_t            quotient_r;
  data_t            remainder_r;
  data_t            fix_quot;
  data_t            fix_rem;
  logic             accept;
`ifdef DIV_CTRL_ZERO_FAST_EN
  logic             zero_r;
  data_t            dividend_raw;
`endif

  // flush wins over start, so a flushed cycle never counts as an accept
  assign accept = bus.start && !bus.flush &&
                  (state == DIVC_IDLE || state == DIVC_DONE);

  assign bus.busy      = busy_r | accept;
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;

  div_sign_fix u_sign_fix (
    .quot_mag (div_dout[DDATA_W-1:DATA_W]),
    .rem_mag  (div_dout[DATA_W-1:0]),
    .neg_quot (neg_quot),
    .neg_rem  (neg_rem),
    .quot     (fix_quot),
    .rem      (fix_rem)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= DIVC_IDLE;
      counter      <= '0;
      neg_quot     <= 1'b0;
      neg_rem      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      quotient_r   <= '0;
      remainder_r  <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
`ifdef DIV_CTRL_ZERO_FAST_EN
      zero_r       <= 1'b0;
      dividend_raw <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      if (bus.flush) begin
        state   <= DIVC_IDLE;
        busy_r  <= 1'b0;
        counter <= '0;
      end else begin
        case (state)
          DIVC_IDLE, DIVC_DONE: begin
            if (bus.start) begin
              neg_rem  <= bus.signed_div & bus.dividend[DATA_W-1];
              neg_quot <= bus.signed_div &
                          (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
              busy_r   <= 1'b1;
`ifdef DIV_CTRL_ZERO_FAST_EN
              zero_r       <= (bus.divisor == '0);
              dividend_raw <= bus.dividend;
              if (bus.divisor == '0) begin
                // IP is bypassed entirely; its operands keep their old values
                state <= DIVC_FIX;
              end else begin
                div_dividend <= cond_neg(bus.dividend,
                                         bus.signed_div & bus.dividend[DATA_W-1]);
                div_divisor  <= cond_neg(bus.divisor,
                                         bus.signed_div & bus.divisor[DATA_W-1]);
                state        <= DIVC_ISSUE;
              end
`else
              div_dividend <= cond_neg(bus.dividend,
                                       bus.signed_div & bus.dividend[DATA_W-1]);
              div_divisor  <= cond_neg(bus.divisor,
                                       bus.signed_div & bus.divisor[DATA_W-1]);
              state        <= DIVC_ISSUE;
`endif
            end else begin
              state <= DIVC_IDLE;
            end
          end
          DIVC_ISSUE: begin
            counter <= CNT_LOAD;
            state   <= DIVC_WAIT;
          end
          DIVC_WAIT: begin
            if (counter == '0) begin
              state <= DIVC_FIX;
            end else begin
              counter <= counter - CNT_W'(1);
            end
          end
          DIVC_FIX: begin
`ifdef DIV_CTRL_ZERO_FAST_EN
            if (zero_r) begin
              quotient_r  <= '1;
              remainder_r <= dividend_raw;
            end else begin
              quotient_r  <= fix_quot;
              remainder_r <= fix_rem;
            end
`else
            quotient_r  <= fix_quot;
            remainder_r <= fix_rem;
`endif
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DIVC_DONE;
          end
          default: state <= DIVC_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural div_gen_0 model and a
// result scoreboard checked whenever done pulses.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int L = 36;
`ifdef DIV_CTRL_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = L + 2;
`endif

  typedef struct packed {
    data_t q;
    data_t r;
  } exp_t;

  logic   clk;
  logic   rst;
  data_t  div_dividend;
  data_t  div_divisor;
  ddata_t div_dout;
  ddata_t pipe [L];

  exp_t   sb [$];
  int     checks;
  int     errors;
  int     lat;

  div_ctrl_if bus ();

  div_ctrl #(.DIV_LATENCY(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_dout     (div_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // div_gen_0 stand-in: unsigned divide, result valid L cycles after inputs settle
  function automatic ddata_t ip_div(input data_t a, input data_t b);
    if (b == '0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= ip_div(div_dividend, div_divisor);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign div_dout = pipe[L-1];

  function automatic exp_t ref_div(input logic sd, input data_t a, input data_t b);
    exp_t e;
    if (!sd) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = '0;
    end else begin
      e.q = data_t'($signed(a) / $signed(b));
      e.r = data_t'($signed(a) % $signed(b));
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'b0, bus.done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
      end
    end
  end

  task automatic issue_op(input logic sd, input data_t a, input data_t b);
    bus.signed_div = sd;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.start      = 1'b1;
    #1;
    check("busy_on_accept", {31'b0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accepting edge until done; start stays high for 'hold' cycles.
  task automatic wait_done(input int hold, output int edges);
    logic busy_ok;
    busy_ok   = 1'b1;
    edges     = 0;
    bus.start = (hold > 0);
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      bus.start = (edges < hold);
    end
    bus.start = 1'b0;
    check("busy_held", {31'b0, busy_ok}, 32'd1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.flush      = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_div_dividend", div_dividend, 32'd0);
    check("rst_div_divisor", div_divisor, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // DIVU 142/12 with latency and busy checks
    sb.push_back('{q: 32'd11, r: 32'd10});
    issue_op(1'b0, 32'd142, 32'd12);
    check("ip_dividend_divu", div_dividend, 32'd142);
    wait_done(0, lat);
    check("latency_divu", lat, L + 2);
    check("busy_at_done", {31'b0, bus.busy}, 32'd0);

    sb.push_back('{q: 32'h071C_71C8, r: 32'h0000_0002});
    issue_op(1'b0, 32'h8000_0012, 32'h0000_0012);
    wait_done(0, lat);
    check("latency_divu_big", lat, L + 2);

    // DIV -7/2: IP sees magnitudes, held through to done
    sb.push_back('{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF});
    issue_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    check("ip_dividend_mag", div_dividend, 32'd7);
    check("ip_divisor_mag", div_divisor, 32'd2);
    wait_done(0, lat);
    check("ip_dividend_held", div_dividend, 32'd7);

    sb.push_back('{q: 32'h8000_0000, r: 32'h0000_0000});
    issue_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ip_dividend_minint", div_dividend, 32'h8000_0000);
    check("ip_divisor_minus1", div_divisor, 32'd1);
    wait_done(0, lat);
    check("latency_div_minint", lat, L + 2);

    // flush 5 cycles into WAIT, then an immediate new op
    issue_op(1'b0, 32'd1000, 32'd3);
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("busy_after_flush", {31'b0, bus.busy}, 32'd0);
    check("done_after_flush", {31'b0, bus.done}, 32'd0);
    sb.push_back('{q: 32'd14, r: 32'd2});
    issue_op(1'b0, 32'd100, 32'd7);
    wait_done(0, lat);
    check("latency_after_flush", lat, L + 2);

    // flush and start together in IDLE: start is dropped
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1 check("busy_flush_start", {31'b0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("idle_after_flush_start", {31'b0, bus.busy}, 32'd0);

    // start held during WAIT is ignored, operands changing underneath
    sb.push_back('{q: 32'd10, r: 32'd0});
    issue_op(1'b0, 32'd50, 32'd5);
    bus.dividend = 32'd999;
    bus.divisor  = 32'd3;
    wait_done(10, lat);
    check("latency_start_held", lat, L + 2);

    // start in DONE cycle: back-to-back accept
    sb.push_back('{q: 32'd9, r: 32'd0});
    issue_op(1'b0, 32'd81, 32'd9);
    wait_done(0, lat);
    sb.push_back('{q: 32'd30, r: 32'd10});
    issue_op(1'b0, 32'd1000, 32'd33);
    wait_done(0, lat);
    check("latency_back_to_back", lat, L + 2);

    // a few pseudo-random ops against the reference model
    for (int n = 0; n < 4; n++) begin
      logic  sd;
      data_t a;
      data_t b;
      sd = n[0];
      a  = $urandom;
      b  = $urandom_range(1, 1000);
      if (n == 3) b = data_t'(-b);
      sb.push_back(ref_div(sd, a, b));
      issue_op(sd, a, b);
      wait_done(0, lat);
    end

    // asynchronous reset in the middle of WAIT
    issue_op(1'b0, 32'd77, 32'd7);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_quotient", bus.quotient, 32'd0);
    check("midrst_remainder", bus.remainder, 32'd0);
    check("midrst_div_dividend", div_dividend, 32'd0);
    check("midrst_div_divisor", div_divisor, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // divide by zero
    sb.push_back('{q: 32'hFFFF_FFFF, r: 32'd5});
    issue_op(1'b0, 32'd5, 32'd0);
`ifdef DIV_CTRL_ZERO_FAST_EN
    check("zero_ip_untouched", div_dividend, 32'd0);
`endif
    wait_done(0, lat);
    check("latency_div_zero", lat, ZERO_LAT);

    repeat (4) @(posedge clk);
    #1 check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
